// File: rtl/srio_initiator_chmux.sv
// srio_initiator_chmux
//   Multi-channel SRIO initiator manager. Each channel buffers 64-bit samples
//   in its own ring buffer. When a channel holds a full burst, a round-robin
//   arbiter selects it and the block issues an NWRITE through the SRIO core
//   ucfg_* interface, then serves the core's initiator reads from that buffer.
//   After FRAME_BURSTS bursts on a channel, a doorbell carrying the channel ID
//   and frame count is sent.
//
// Ports
//   sys_clk, sys_rst        srio user clock, synchronous active-high reset
//   enable                  arbitration enable (no new burst while low)
//   ch_wr_en, ch_wr_data    per-channel sample write strobe / data
//   ch_full, ch_overflow    per-channel full flag / sticky overflow flag
//   initiator_rden/addr     core read strobe and byte address
//   initiator_dout          registered read data (1 cycle after rden)
//   srio_initial_busy       core busy
//   srio_db_resp            doorbell response pulse (counted in db_resp_cnt)
//   ucfg_*                  SRIO core request configuration and triggers
//   frame_done              pulse when a doorbell completes
//
// FSM states
//   state        | meaning
//   S_IDLE       | wait for a grant (enable=1, busy=0, some channel ready)
//   S_CFG        | latch destination address of the granted channel
//   S_TRIG       | pulse ucfg_normal_trigger
//   S_WAIT_HI    | wait for busy to rise, re-trigger on timeout
//   S_WAIT_LO    | serve reads; busy falling completes the burst
//   S_DB_CFG     | latch doorbell payload
//   S_DB_TRIG    | pulse ucfg_db_trigger
//   S_DB_WAIT_HI | wait for busy to rise, re-trigger on timeout
//   S_DB_WAIT_LO | busy falling completes the doorbell
module srio_initiator_chmux #(
    parameter int          CH_NUM       = 3,
    parameter int          DEPTH        = 128,
    parameter int          BURST_WORDS  = 32,
    parameter int          FRAME_BURSTS = 16,
    parameter logic [33:0] DEST_BASE    = 34'h0,
    parameter logic [33:0] CH_STRIDE    = 34'h10000,
    parameter logic [7:0]  DEST_ID      = 8'h01,
    parameter int          TRIG_TIMEOUT = 64
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   enable,
    input  logic [CH_NUM-1:0]      ch_wr_en,
    input  logic [64*CH_NUM-1:0]   ch_wr_data,
    output logic [CH_NUM-1:0]      ch_full,
    output logic [CH_NUM-1:0]      ch_overflow,
    input  logic                   initiator_rden,
    input  logic [31:0]            initiator_addr,
    output logic [63:0]            initiator_dout,
    input  logic                   srio_initial_busy,
    input  logic                   srio_db_resp,
    output logic [7:0]             ucfg_dest_id,
    output logic [31:0]            ucfg_src_start_addr,
    output logic [33:0]            ucfg_dest_start_addr,
    output logic [8:0]             ucfg_byte_count,
    output logic [15:0]            ucfg_db_info,
    output logic                   ucfg_wr_n,
    output logic                   ucfg_normal_trigger,
    output logic                   ucfg_db_trigger,
    output logic                   frame_done,
    output logic [15:0]            db_resp_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OW  = $clog2(BURST_WORDS);
    localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int BIW = $clog2(FRAME_BURSTS + 1);
    localparam int TW  = $clog2(TRIG_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_TRIG, S_WAIT_HI, S_WAIT_LO,
        S_DB_CFG, S_DB_TRIG, S_DB_WAIT_HI, S_DB_WAIT_LO
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [63:0]       r_mem   [CH_NUM][DEPTH];
    logic [AW-1:0]     r_wp    [CH_NUM];
    logic [AW-1:0]     r_rbase [CH_NUM];
    logic [CW-1:0]     r_cnt   [CH_NUM];
    logic [BIW-1:0]    r_bidx  [CH_NUM];
    logic [11:0]       r_fcnt  [CH_NUM];
    logic [CHW-1:0]    r_ch, r_last;
    logic [TW-1:0]     r_tmr;
    logic [33:0]       r_dest;
    logic [15:0]       r_db_info;
    logic [63:0]       r_dout;
    logic [CH_NUM-1:0] r_ovf;
    logic              r_frame_done;
    logic [15:0]       r_db_resp_cnt;

    logic [CH_NUM-1:0] w_req, w_wr_ok, w_full;
    logic              w_gnt_vld;
    logic [CHW-1:0]    w_gnt_ch, w_rr_idx;
    logic              w_trig, w_db_trig, w_burst_done, w_db_done, w_last_burst;
    logic              w_in_window;
    logic [AW-1:0]     w_rd_idx;
    logic              w_unused;

    // Only the word-offset bits of the core address select data.
    assign w_unused = ^{initiator_addr[31:3+OW], initiator_addr[2:0]};

    always_comb begin
        w_req   = '0;
        w_wr_ok = '0;
        w_full  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            w_full[k]  = (r_cnt[k] == CW'(DEPTH));
            w_req[k]   = (r_cnt[k] >= CW'(BURST_WORDS));
            w_wr_ok[k] = ch_wr_en[k] && !w_full[k];
        end
    end

    // Scan from farthest to nearest after r_last so the nearest ready channel wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_rr_idx  = '0;
        for (int i = CH_NUM; i >= 1; i--) begin
            w_rr_idx = CHW'((int'(r_last) + i) % CH_NUM);
            if (w_req[w_rr_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_rr_idx;
            end
        end
    end

    assign w_last_burst = (r_bidx[r_ch] == BIW'(FRAME_BURSTS - 1));
    assign w_in_window  = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
    assign w_rd_idx     = r_rbase[r_ch] + AW'(initiator_addr[3+OW-1:3]);

    always_comb begin
        w_state_nxt  = r_state;
        w_trig       = 1'b0;
        w_db_trig    = 1'b0;
        w_burst_done = 1'b0;
        w_db_done    = 1'b0;
        case (r_state)
            S_IDLE:       if (enable && !srio_initial_busy && w_gnt_vld) w_state_nxt = S_CFG;
            S_CFG:        w_state_nxt = S_TRIG;
            S_TRIG: begin
                w_trig      = 1'b1;
                w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (srio_initial_busy)  w_state_nxt = S_WAIT_LO;
                else if (r_tmr == '0)   w_state_nxt = S_TRIG;
            end
            S_WAIT_LO: begin
                if (!srio_initial_busy) begin
                    w_burst_done = 1'b1;
                    w_state_nxt  = w_last_burst ? S_DB_CFG : S_IDLE;
                end
            end
            S_DB_CFG:     w_state_nxt = S_DB_TRIG;
            S_DB_TRIG: begin
                w_db_trig   = 1'b1;
                w_state_nxt = S_DB_WAIT_HI;
            end
            S_DB_WAIT_HI: begin
                if (srio_initial_busy)  w_state_nxt = S_DB_WAIT_LO;
                else if (r_tmr == '0)   w_state_nxt = S_DB_TRIG;
            end
            S_DB_WAIT_LO: begin
                if (!srio_initial_busy) begin
                    w_db_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // Buffer storage carries no reset; validity is tracked by r_cnt alone.
    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_wr_ok[k]) r_mem[k][r_wp[k]] <= ch_wr_data[64*k +: 64];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_ch          <= '0;
            r_last        <= CHW'(CH_NUM - 1);
            r_tmr         <= '0;
            r_dest        <= '0;
            r_db_info     <= '0;
            r_dout        <= '0;
            r_ovf         <= '0;
            r_frame_done  <= 1'b0;
            r_db_resp_cnt <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                r_wp[k]    <= '0;
                r_rbase[k] <= '0;
                r_cnt[k]   <= '0;
                r_bidx[k]  <= '0;
                r_fcnt[k]  <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_db_done;
            if (srio_db_resp) r_db_resp_cnt <= r_db_resp_cnt + 16'd1;
            if (r_state == S_IDLE && w_state_nxt == S_CFG) begin
                r_ch   <= w_gnt_ch;
                r_last <= w_gnt_ch;
            end
            if (r_state == S_CFG)
                r_dest <= DEST_BASE + 34'(r_ch) * CH_STRIDE
                        + 34'(r_bidx[r_ch]) * 34'(BURST_WORDS * 8);
            if (r_state == S_DB_CFG)
                r_db_info <= {4'(r_ch), r_fcnt[r_ch]};
            if (w_trig || w_db_trig)  r_tmr <= TW'(TRIG_TIMEOUT - 1);
            else if (r_tmr != '0)     r_tmr <= r_tmr - 1'b1;
            if (initiator_rden)
                r_dout <= w_in_window ? r_mem[r_ch][w_rd_idx] : 64'd0;
            for (int k = 0; k < CH_NUM; k++) begin
                if (w_wr_ok[k]) r_wp[k] <= r_wp[k] + 1'b1;
                if (ch_wr_en[k] && !w_wr_ok[k]) r_ovf[k] <= 1'b1;
                // Words of the active burst stay counted until busy falls, so
                // writes can never overrun data the core has yet to read.
                if (w_burst_done && r_ch == CHW'(k)) begin
                    r_cnt[k]   <= r_cnt[k] + CW'(w_wr_ok[k]) - CW'(BURST_WORDS);
                    r_rbase[k] <= r_rbase[k] + AW'(BURST_WORDS);
                    r_bidx[k]  <= w_last_burst ? '0 : r_bidx[k] + 1'b1;
                end else begin
                    r_cnt[k]   <= r_cnt[k] + CW'(w_wr_ok[k]);
                end
                if (w_db_done && r_ch == CHW'(k)) r_fcnt[k] <= r_fcnt[k] + 12'd1;
            end
        end
    end

    assign ch_full              = w_full;
    assign ch_overflow          = r_ovf;
    assign initiator_dout       = r_dout;
    assign ucfg_dest_id         = DEST_ID;
    assign ucfg_src_start_addr  = 32'd0;
    assign ucfg_dest_start_addr = r_dest;
    assign ucfg_byte_count      = 9'(BURST_WORDS * 8);
    assign ucfg_db_info         = r_db_info;
    assign ucfg_wr_n            = 1'b0;
    assign ucfg_normal_trigger  = w_trig;
    assign ucfg_db_trigger      = w_db_trig;
    assign frame_done           = r_frame_done;
    assign db_resp_cnt          = r_db_resp_cnt;

endmodule

// File: tb/tb_srio_initiator_chmux.sv
module tb_srio_initiator_chmux;
    localparam int CH    = 3;
    localparam int DEPTH = 128;
    localparam int BW    = 32;
    localparam int FB    = 16;
    localparam int TO    = 64;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              enable = 1'b0;
    logic [CH-1:0]     ch_wr_en = '0;
    logic [64*CH-1:0]  ch_wr_data = '0;
    logic [CH-1:0]     ch_full, ch_overflow;
    logic              initiator_rden = 1'b0;
    logic [31:0]       initiator_addr = '0;
    logic [63:0]       initiator_dout;
    logic              srio_initial_busy = 1'b0;
    logic              srio_db_resp = 1'b0;
    logic [7:0]        ucfg_dest_id;
    logic [31:0]       ucfg_src_start_addr;
    logic [33:0]       ucfg_dest_start_addr;
    logic [8:0]        ucfg_byte_count;
    logic [15:0]       ucfg_db_info;
    logic              ucfg_wr_n, ucfg_normal_trigger, ucfg_db_trigger, frame_done;
    logic [15:0]       db_resp_cnt;

    always #5 sys_clk = ~sys_clk;

    srio_initiator_chmux #(
        .CH_NUM(CH), .DEPTH(DEPTH), .BURST_WORDS(BW), .FRAME_BURSTS(FB),
        .DEST_BASE(34'h0), .CH_STRIDE(34'h10000), .DEST_ID(8'h01), .TRIG_TIMEOUT(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .ch_wr_en(ch_wr_en), .ch_wr_data(ch_wr_data),
        .ch_full(ch_full), .ch_overflow(ch_overflow),
        .initiator_rden(initiator_rden), .initiator_addr(initiator_addr),
        .initiator_dout(initiator_dout),
        .srio_initial_busy(srio_initial_busy), .srio_db_resp(srio_db_resp),
        .ucfg_dest_id(ucfg_dest_id), .ucfg_src_start_addr(ucfg_src_start_addr),
        .ucfg_dest_start_addr(ucfg_dest_start_addr), .ucfg_byte_count(ucfg_byte_count),
        .ucfg_db_info(ucfg_db_info), .ucfg_wr_n(ucfg_wr_n),
        .ucfg_normal_trigger(ucfg_normal_trigger), .ucfg_db_trigger(ucfg_db_trigger),
        .frame_done(frame_done), .db_resp_cnt(db_resp_cnt)
    );

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          ch;
        logic [33:0] addr;
        bit          db;
    } burst_t;
    typedef logic [63:0] wq_t[$];

    int          total = 0;
    int          bad   = 0;
    burst_t      plan_q[$];
    logic [63:0] plan_words[$];
    logic [33:0] exp_trig[$];
    logic [15:0] exp_db[$];
    logic [63:0] exp_rd[$];
    wq_t         mq [CH];
    int          m_bidx [CH];
    int          m_fcnt [CH];
    bit          m_ovf [CH];
    int          m_last = CH - 1;
    int          fd_exp = 0;
    int          fd_seen = 0;
    int          db_resp_n = 0;
    logic        rd_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            mq[k].delete();
            m_bidx[k] = 0;
            m_fcnt[k] = 0;
            m_ovf[k]  = 1'b0;
        end
        m_last    = CH - 1;
        db_resp_n = 0;
    endtask

    // Every channel holding a full burst is served, next-after-last first.
    task automatic plan_drain();
        int     found;
        burst_t b;
        forever begin
            found = -1;
            for (int i = 1; i <= CH; i++) begin
                if (found < 0 && mq[(m_last + i) % CH].size() >= BW) found = (m_last + i) % CH;
            end
            if (found < 0) break;
            m_last = found;
            b.ch   = found;
            b.addr = 34'(found) * 34'h10000 + 34'(m_bidx[found]) * 34'd256;
            b.db   = 1'b0;
            for (int i = 0; i < BW; i++) plan_words.push_back(mq[found].pop_front());
            m_bidx[found]++;
            if (m_bidx[found] == FB) begin
                m_bidx[found] = 0;
                b.db = 1'b1;
                exp_db.push_back({4'(found), 12'(m_fcnt[found])});
                m_fcnt[found] = (m_fcnt[found] + 1) % 4096;
                fd_exp++;
            end
            exp_trig.push_back(b.addr);
            plan_q.push_back(b);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge sys_clk) rd_seen <= initiator_rden;

    always @(negedge sys_clk) begin
        if (rd_seen) begin
            if (exp_rd.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected actual=0x%0h required=none", initiator_dout);
            end else chk("rd_data", initiator_dout, exp_rd.pop_front());
        end
        if (ucfg_normal_trigger) begin
            if (exp_trig.size() == 0) begin
                total++; bad++;
                $display("FAIL trig_unexpected actual_addr=0x%0h required=no trigger", ucfg_dest_start_addr);
            end else begin
                chk("dest_addr", 64'(ucfg_dest_start_addr), 64'(exp_trig.pop_front()));
                chk("byte_count", 64'(ucfg_byte_count), 64'd256);
            end
        end
        if (ucfg_db_trigger) begin
            if (exp_db.size() == 0) begin
                total++; bad++;
                $display("FAIL db_unexpected actual_info=0x%0h required=no doorbell", ucfg_db_info);
            end else chk("db_info", 64'(ucfg_db_info), 64'(exp_db.pop_front()));
        end
        if (frame_done) fd_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wr_all(input int n0, input int n1, input int n2, input bit seq);
        int          n [CH];
        int          mx;
        logic [63:0] d;
        n[0] = n0; n[1] = n1; n[2] = n2;
        mx = n0;
        if (n1 > mx) mx = n1;
        if (n2 > mx) mx = n2;
        for (int i = 0; i < mx; i++) begin
            @(posedge sys_clk); #1;
            for (int k = 0; k < CH; k++) begin
                if (i < n[k]) begin
                    d = seq ? 64'(i) : {$urandom(), $urandom()};
                    ch_wr_en[k] = 1'b1;
                    ch_wr_data[64*k +: 64] = d;
                    if (mq[k].size() < DEPTH) mq[k].push_back(d);
                    else m_ovf[k] = 1'b1;
                end else ch_wr_en[k] = 1'b0;
            end
        end
        @(posedge sys_clk); #1;
        ch_wr_en = '0;
    endtask

    // which: 0 normal trigger, 1 doorbell trigger, 2 frame_done
    task automatic wait_sig(input int which, input int lim, input string name, output int waited);
        bit hit = 1'b0;
        waited = 0;
        while (!hit && waited < lim) begin
            @(negedge sys_clk);
            waited++;
            hit = (which == 0) ? ucfg_normal_trigger : (which == 1) ? ucfg_db_trigger : frame_done;
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no pulse in %0d cycles required=pulse", name, lim);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic serve_burst(input bit no_busy_first, input bit seq_rd);
        burst_t      b;
        logic [63:0] w [BW];
        int          t, off;
        logic [31:0] r;
        b = plan_q.pop_front();
        for (int i = 0; i < BW; i++) w[i] = plan_words.pop_front();
        wait_sig(0, 300, "trigger", t);
        if (no_busy_first) begin
            exp_trig.push_front(b.addr);
            wait_sig(0, TO + 20, "retrigger", t);
            // trigger pulses are TRIG_TIMEOUT waiting cycles plus the trigger cycle apart
            chk("retrig_gap", 64'(t), 64'(TO + 1));
        end
        cyc($urandom_range(0, 4));
        srio_initial_busy = 1'b1;
        for (int j = 0; j < BW; j++) begin
            off = seq_rd ? j : $urandom_range(0, BW - 1);
            r = $urandom();
            initiator_rden = 1'b1;
            initiator_addr = seq_rd ? 32'(off * 8) : {r[31:8], 5'(off), r[2:0]};
            exp_rd.push_back(w[off]);
            cyc(1);
            initiator_rden = 1'b0;
            if (!seq_rd && $urandom_range(0, 3) == 0) cyc(1);
        end
        cyc(2);
        srio_initial_busy = 1'b0;
        cyc(1);
        if (b.db) begin
            wait_sig(1, 50, "db_trigger", t);
            cyc($urandom_range(0, 4));
            srio_initial_busy = 1'b1;
            srio_db_resp = 1'b1;
            cyc(1);
            srio_db_resp = 1'b0;
            db_resp_n++;
            cyc($urandom_range(0, 3));
            srio_initial_busy = 1'b0;
            wait_sig(2, 10, "frame_done", t);
        end
    endtask

    task automatic drain(input bit no_busy_first);
        bit first = no_busy_first;
        plan_drain();
        enable = 1'b1;
        while (plan_q.size() > 0) begin
            serve_burst(first, 1'b0);
            first = 1'b0;
        end
        cyc(2);
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_full"},      64'(ch_full), 64'd0);
        chk({tag, "_overflow"},  64'(ch_overflow), 64'd0);
        chk({tag, "_dout"},      initiator_dout, 64'd0);
        chk({tag, "_dest_id"},   64'(ucfg_dest_id), 64'h01);
        chk({tag, "_src_addr"},  64'(ucfg_src_start_addr), 64'd0);
        chk({tag, "_dest_addr"}, 64'(ucfg_dest_start_addr), 64'd0);
        chk({tag, "_byte_cnt"},  64'(ucfg_byte_count), 64'd256);
        chk({tag, "_db_info"},   64'(ucfg_db_info), 64'd0);
        chk({tag, "_wr_n"},      64'(ucfg_wr_n), 64'd0);
        chk({tag, "_triggers"},  64'({ucfg_normal_trigger, ucfg_db_trigger, frame_done}), 64'd0);
        chk({tag, "_db_resp"},   64'(db_resp_cnt), 64'd0);
    endtask

    task automatic chk_flags(input string tag);
        for (int k = 0; k < CH; k++) begin
            chk({tag, "_full"}, 64'(ch_full[k]), 64'(mq[k].size() == DEPTH));
            chk({tag, "_ovf"},  64'(ch_overflow[k]), 64'(m_ovf[k]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        burst_t      rb;
        logic [63:0] rw [BW];
        int          t;
        model_reset();
        cyc(3);
        sys_rst = 1'b0;
        cyc(1);
        chk_reset_outputs("reset");

        // single channel, sequential data and addresses
        enable = 1'b1;
        wr_all(32, 0, 0, 1'b1);
        plan_drain();
        serve_burst(1'b0, 1'b1);
        wr_all(31, 0, 0, 1'b0);
        cyc(20);
        enable = 1'b0;
        chk_flags("partial");

        // read outside a burst window returns zero
        initiator_rden = 1'b1;
        initiator_addr = 32'h18;
        exp_rd.push_back(64'd0);
        cyc(1);
        initiator_rden = 1'b0;
        cyc(2);

        // all channels ready at once, ch1 holding two bursts
        wr_all(32, 64, 32, 1'b0);
        drain(1'b0);

        // busy never rises after the first trigger
        wr_all(32, 0, 0, 1'b0);
        drain(1'b1);

        // two full frames on ch2 plus one burst into the third frame
        for (int i = 0; i < 32; i++) begin
            wr_all(0, 0, 32, 1'b0);
            drain(1'b0);
        end
        chk("frames_ch2", 64'(fd_seen), 64'(fd_exp));

        // overflow while arbitration is disabled
        wr_all(129, 0, 0, 1'b0);
        cyc(1);
        chk_flags("overflow");
        drain(1'b0);
        chk_flags("after_drain");

        // randomized fill/drain rounds
        for (int r = 0; r < 4; r++) begin
            wr_all($urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120), 1'b0);
            cyc(1);
            chk_flags("rand");
            drain(1'b0);
        end

        repeat ($urandom_range(2, 6)) begin
            srio_db_resp = 1'b1;
            cyc(1);
            srio_db_resp = 1'b0;
            db_resp_n++;
            cyc($urandom_range(0, 2));
        end
        chk("db_resp_cnt", 64'(db_resp_cnt), 64'(db_resp_n));

        // reset in the middle of a burst
        wr_all(0, 32, 0, 1'b0);
        plan_drain();
        enable = 1'b1;
        rb = plan_q.pop_front();
        for (int i = 0; i < BW; i++) rw[i] = plan_words.pop_front();
        wait_sig(0, 300, "rst_trigger", t);
        srio_initial_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            initiator_rden = 1'b1;
            initiator_addr = 32'(i * 8);
            exp_rd.push_back(rw[i]);
            cyc(1);
        end
        initiator_rden = 1'b0;
        cyc(3);
        sys_rst = 1'b1;
        cyc(1);
        chk_reset_outputs("midrst");
        sys_rst = 1'b0;
        srio_initial_busy = 1'b0;
        enable = 1'b0;
        model_reset();
        cyc(2);
        wr_all(0, 31, 32, 1'b0);
        drain(1'b0);
        chk_flags("post_rst");

        cyc(10);
        chk("frame_done_count", 64'(fd_seen), 64'(fd_exp));
        chk("trig_left", 64'(exp_trig.size()), 64'd0);
        chk("db_left", 64'(exp_db.size()), 64'd0);
        chk("rd_left", 64'(exp_rd.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=simulation still running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end
endmodule
